// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush control for the 5-stage pipeline.
// Keeps a small bubble FSM and saturating stall/flush event counters.
module hazard_detection_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead_EX_i,
  input  logic [4:0]           rd_EX_i,
  input  logic [4:0]           rs1_ID_i,
  input  logic [4:0]           rs2_ID_i,
  input  logic                 use_rs1_ID_i,
  input  logic                 use_rs2_ID_i,
  input  logic                 branch_taken_EX_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic [1:0]           hazard_state_o,
  output logic [CNT_WIDTH-1:0] stall_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01
  } state_t;

  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI    = (LOAD_STALL_CYCLES > 1);

  state_t               state;
  logic [3:0]           rem;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic in_stall;
  logic stall_cyc;
  logic stall_sat;
  logic flush_sat;

  assign rs1_hit  = use_rs1_ID_i && (rs1_ID_i == rd_EX_i);
  assign rs2_hit  = use_rs2_ID_i && (rs2_ID_i == rd_EX_i);
  assign load_use = MemRead_EX_i && (rd_EX_i != 5'd0)
                 && (rs1_hit || rs2_hit);
  assign in_stall = (state == STALL);

  // A stall cycle is either a held bubble or a fresh load-use in RUN.
  assign stall_cyc = !branch_taken_EX_i && (in_stall || load_use);

  assign stall_sat = &stall_cnt;
  assign flush_sat = &flush_cnt;

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (reset) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (branch_taken_EX_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (stall_cyc) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      rem       <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (branch_taken_EX_i) begin
      state <= RUN;
      rem   <= 4'd0;
      if (!flush_sat)
        flush_cnt <= flush_cnt + 1'b1;
    end else if (in_stall) begin
      rem <= rem - 4'd1;
      if (rem == 4'd1)
        state <= RUN;
      if (!stall_sat)
        stall_cnt <= stall_cnt + 1'b1;
    end else if (load_use) begin
      if (MULTI) begin
        state <= STALL;
        rem   <= REM_INIT;
      end
      if (!stall_sat)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hazard_state_o = state;
  assign stall_count_o  = stall_cnt;
  assign flush_count_o  = flush_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Drives three hazard unit configurations with shared stimulus and
// compares every cycle against a pending-bubble reference model.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       u1;
  logic       u2;
  logic       br;

  logic        pc_w [3];
  logic        ifid_w [3];
  logic        ifid_f [3];
  logic        idex_f [3];
  logic [1:0]  st [3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int lsc [3] = '{1, 3, 1};
  int cw  [3] = '{16, 16, 4};

  int pend [3];
  int scnt [3];
  int fcnt [3];
  bit known;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) u_l1 (
    .clk(clk), .reset(rst), .MemRead_EX_i(mem), .rd_EX_i(rd),
    .rs1_ID_i(rs1), .rs2_ID_i(rs2), .use_rs1_ID_i(u1),
    .use_rs2_ID_i(u2), .branch_taken_EX_i(br),
    .pc_write_o(pc_w[0]), .if_id_write_o(ifid_w[0]),
    .if_id_flush_o(ifid_f[0]), .id_ex_flush_o(idex_f[0]),
    .hazard_state_o(st[0]), .stall_count_o(sc0),
    .flush_count_o(fc0)
  );

  hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(16)) u_l3 (
    .clk(clk), .reset(rst), .MemRead_EX_i(mem), .rd_EX_i(rd),
    .rs1_ID_i(rs1), .rs2_ID_i(rs2), .use_rs1_ID_i(u1),
    .use_rs2_ID_i(u2), .branch_taken_EX_i(br),
    .pc_write_o(pc_w[1]), .if_id_write_o(ifid_w[1]),
    .if_id_flush_o(ifid_f[1]), .id_ex_flush_o(idex_f[1]),
    .hazard_state_o(st[1]), .stall_count_o(sc1),
    .flush_count_o(fc1)
  );

  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(4)) u_w4 (
    .clk(clk), .reset(rst), .MemRead_EX_i(mem), .rd_EX_i(rd),
    .rs1_ID_i(rs1), .rs2_ID_i(rs2), .use_rs1_ID_i(u1),
    .use_rs2_ID_i(u2), .branch_taken_EX_i(br),
    .pc_write_o(pc_w[2]), .if_id_write_o(ifid_w[2]),
    .if_id_flush_o(ifid_f[2]), .id_ex_flush_o(idex_f[2]),
    .hazard_state_o(st[2]), .stall_count_o(sc2),
    .flush_count_o(fc2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit dep();
    bit a = u1 && rs1 == rd;
    bit b = u2 && rs2 == rd;
    return mem && rd != 0 && (a || b);
  endfunction

  function automatic int sat_inc(int v, int w);
    int top = (1 << w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush}
  function automatic logic [3:0] exp_ctl(int k);
    if (rst) return 4'b0011;
    if (br) return 4'b1111;
    if (pend[k] > 0 || dep()) return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic check_now(string tag);
    logic [15:0] sc [3];
    logic [15:0] fc [3];
    sc[0] = sc0; sc[1] = sc1; sc[2] = {12'd0, sc2};
    fc[0] = fc0; fc[1] = fc1; fc[2] = {12'd0, fc2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.ctl%0d", tag, k),
          {28'd0, pc_w[k], ifid_w[k], ifid_f[k], idex_f[k]},
          {28'd0, exp_ctl(k)});
      if (known) begin
        chk($sformatf("%s.st%0d", tag, k), {30'd0, st[k]},
            (pend[k] > 0) ? 32'd1 : 32'd0);
        chk($sformatf("%s.sc%0d", tag, k), {16'd0, sc[k]}, scnt[k]);
        chk($sformatf("%s.fc%0d", tag, k), {16'd0, fc[k]}, fcnt[k]);
      end
    end
  endtask

  task automatic update_model();
    bit lu = dep();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else if (br) begin
        pend[k] = 0;
        fcnt[k] = sat_inc(fcnt[k], cw[k]);
      end else if (pend[k] > 0) begin
        pend[k]--;
        scnt[k] = sat_inc(scnt[k], cw[k]);
      end else if (lu) begin
        scnt[k] = sat_inc(scnt[k], cw[k]);
        pend[k] = lsc[k] - 1;
      end
    end
    if (rst) known = 1'b1;
  endtask

  task automatic cyc(string tag, bit r, bit m, logic [4:0] d,
                     logic [4:0] a, logic [4:0] b, bit ua, bit ub,
                     bit t);
    rst = r; mem = m; rd = d; rs1 = a; rs2 = b;
    u1 = ua; u2 = ub; br = t;
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    known = 1'b0;
    rst = 1; mem = 0; rd = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; br = 0;
    @(posedge clk); #1;
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("post_rst");

    // lw x5 then dependent add on rs1; EX becomes bubble afterwards
    cyc("lu_rs1", 0, 1, 5, 5, 0, 1, 0, 0);
    cyc("lu_after", 0, 0, 5, 5, 0, 1, 0, 0);
    cyc("lu_after2", 0, 0, 5, 5, 0, 1, 0, 0);
    idle("idle1");

    // x0 and unused-source cases never stall
    cyc("x0", 0, 1, 0, 0, 0, 1, 1, 0);
    cyc("no_use2", 0, 1, 5, 7, 5, 1, 0, 0);
    cyc("not_load", 0, 0, 5, 5, 5, 1, 1, 0);

    // held rs2 load-use: three bubbles on the LSC=3 unit
    for (int i = 0; i < 4; i++)
      cyc("held_rs2", 0, 1, 9, 0, 9, 0, 1, 0);
    idle("idle2");

    // branch beats load-use in the same cycle
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("br_lu", 0, 1, 6, 6, 6, 1, 1, 1);
    idle("br_after");

    // branch in second stall cycle
    cyc("st_a", 0, 1, 4, 4, 0, 1, 0, 0);
    cyc("st_br", 0, 0, 0, 0, 0, 0, 0, 1);
    idle("st_done");

    // reset mid-stall aborts and clears counters
    cyc("st_b", 0, 1, 4, 4, 0, 1, 0, 0);
    cyc("st_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("rst_done");

    // saturation on the 4-bit unit
    for (int i = 0; i < 20; i++)
      cyc("sat", 0, 1, 3, 3, 3, 1, 1, 0);
    idle("sat_done");
    chk("sat_final", {28'd0, sc2}, 32'd15);

    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 40) == 0),
          $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
